fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 77 +++++++
 tb/tb_fetch_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: REQ/VALID/HALT sequencer that fetches one word at a
// time from instruction memory and presents it to the decoder via ir/pc.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [31:0] pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        exception,
  output logic        halted
);

  localparam logic [1:0] ST_REQ   = 2'd0;
  localparam logic [1:0] ST_VALID = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  localparam logic [31:0] RESET_WORD = {RESET_PC[31:2], 2'b00};

  logic [1:0]  state;
  logic [31:0] fetch_pc;
  logic [31:0] redirect_pc;
  logic        unused_target_bits;

  // Branch targets are word addresses; the low two bits are dropped.
  assign redirect_pc        = {branch_target[31:2], 2'b00};
  assign unused_target_bits = ^branch_target[1:0];

  // The request is masked by rst directly so it never asserts during reset,
  // even in the very first cycle when the state register is not yet known.
  assign imem_req  = (state == ST_REQ) && !rst;
  assign imem_addr = fetch_pc;
  assign ir_valid  = (state == ST_VALID);
  assign halted    = (state == ST_HALT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_REQ;
      fetch_pc <= RESET_WORD;
      pc       <= RESET_WORD;
      ir       <= '0;
    end else begin
      case (state)
        ST_REQ: begin
          if (imem_ack) begin
            ir    <= imem_rdata;
            pc    <= fetch_pc;
            state <= ST_VALID;
          end
        end
        ST_VALID: begin
          if (ir_ready) begin
            if (exception) begin
              state <= ST_HALT;
            end else begin
              fetch_pc <= branch_taken ? redirect_pc : pc + 32'd4;
              state    <= ST_REQ;
            end
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a directed vector table for the main
// fetch/redirect/wrap flow, plus hand sequences for multi-cycle corner cases.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic [31:0] pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        exception;
  logic        halted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .ir            (ir),
    .pc            (pc),
    .ir_valid      (ir_valid),
    .ir_ready      (ir_ready),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .exception     (exception),
    .halted        (halted)
  );

  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        br;
    logic [31:0] tgt;
    logic        exc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_ir;
    logic [31:0] e_pc;
    logic        e_halt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic a, input logic [31:0] d,
                       input logic rdy, input logic b, input logic [31:0] t,
                       input logic e);
    rst = r; imem_ack = a; imem_rdata = d; ir_ready = rdy;
    branch_taken = b; branch_target = t; exception = e;
  endtask

  // Outputs are compared 1 time unit after the inputs settle, well away from the edge.
  task automatic expect_out(input string tag, input logic req, input logic [31:0] addr,
                            input logic valid, input logic [31:0] exp_ir,
                            input logic [31:0] exp_pc, input logic halt);
    #1;
    check({tag, "_req"}, {31'd0, imem_req}, {31'd0, req});
    if (req) check({tag, "_addr"}, imem_addr, addr);
    check({tag, "_valid"}, {31'd0, ir_valid}, {31'd0, valid});
    check({tag, "_ir"}, ir, exp_ir);
    check({tag, "_pc"}, pc, exp_pc);
    check({tag, "_halted"}, {31'd0, halted}, {31'd0, halt});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic a, input logic [31:0] d,
                              input logic rdy, input logic b, input logic [31:0] t,
                              input logic e, input logic ereq, input logic [31:0] eaddr,
                              input logic evalid, input logic [31:0] eir,
                              input logic [31:0] epc, input logic ehalt);
    vec_t v;
    v.rst = r; v.ack = a; v.rdata = d; v.ready = rdy; v.br = b; v.tgt = t; v.exc = e;
    v.e_req = ereq; v.e_addr = eaddr; v.e_valid = evalid; v.e_ir = eir;
    v.e_pc = epc; v.e_halt = ehalt;
    return v;
  endfunction

  initial begin
    // Row inputs are applied for one cycle; expected outputs are those seen
    // before that cycle's rising edge.
    //              rst ack rdata          rdy br tgt            exc  req addr           vld ir             pc             hlt
    vecs.push_back(mk(1, 1, 32'hDEAD_BEEF, 1, 0, 32'h0,         0,   0, 32'h0000_0000, 0, 32'h0,         32'h0,         0));
    vecs.push_back(mk(0, 1, 32'hA000_0000, 1, 0, 32'h0,         0,   1, 32'h0000_0000, 0, 32'h0,         32'h0,         0));
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFF, 1, 0, 32'h0,         0,   0, 32'h0000_0000, 1, 32'hA000_0000, 32'h0,         0));
    vecs.push_back(mk(0, 1, 32'hA000_0004, 1, 0, 32'h0,         0,   1, 32'h0000_0004, 0, 32'hA000_0000, 32'h0,         0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 32'h0,         0,   0, 32'h0000_0004, 1, 32'hA000_0004, 32'h4,         0));
    vecs.push_back(mk(0, 1, 32'hA000_0008, 1, 0, 32'h0,         0,   1, 32'h0000_0008, 0, 32'hA000_0004, 32'h4,         0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 32'h0000_0103, 0,   0, 32'h0000_0008, 1, 32'hA000_0008, 32'h8,         0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 32'h0,         0,   1, 32'h0000_0100, 0, 32'hA000_0008, 32'h8,         0));
    vecs.push_back(mk(0, 1, 32'hB000_0100, 1, 0, 32'h0,         0,   1, 32'h0000_0100, 0, 32'hA000_0008, 32'h8,         0));
    vecs.push_back(mk(0, 1, 32'h1234_5678, 0, 1, 32'h0000_0200, 1,   0, 32'h0000_0100, 1, 32'hB000_0100, 32'h100,       0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 32'hFFFF_FFFE, 0,   0, 32'h0000_0100, 1, 32'hB000_0100, 32'h100,       0));
    vecs.push_back(mk(0, 1, 32'hC000_FFFC, 1, 0, 32'h0,         0,   1, 32'hFFFF_FFFC, 0, 32'hB000_0100, 32'h100,       0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 32'h0,         0,   0, 32'hFFFF_FFFC, 1, 32'hC000_FFFC, 32'hFFFF_FFFC, 0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 32'h0,         0,   1, 32'h0000_0000, 0, 32'hC000_FFFC, 32'hFFFF_FFFC, 0));

    drive(1, 0, 32'h0, 0, 0, 32'h0, 0);
    tick();
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].ack, vecs[i].rdata, vecs[i].ready,
            vecs[i].br, vecs[i].tgt, vecs[i].exc);
      expect_out($sformatf("row%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                 vecs[i].e_ir, vecs[i].e_pc, vecs[i].e_halt);
      tick();
    end

    // Redirect to 0x10, then ack arrives only on the fourth request cycle.
    drive(0, 1, 32'hD000_0000, 1, 0, 32'h0, 0);
    expect_out("pre10_fetch", 1, 32'h0, 0, 32'hC000_FFFC, 32'hFFFF_FFFC, 0);
    tick();
    drive(0, 0, 32'h0, 1, 1, 32'h0000_0010, 0);
    expect_out("pre10_valid", 0, 32'h0, 1, 32'hD000_0000, 32'h0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 32'h0, 1, 0, 32'h0, 0);
      expect_out($sformatf("wait%0d", i), 1, 32'h10, 0, 32'hD000_0000, 32'h0, 0);
      tick();
    end
    drive(0, 1, 32'hD000_0010, 1, 0, 32'h0, 0);
    expect_out("ack10", 1, 32'h10, 0, 32'hD000_0000, 32'h0, 0);
    tick();

    // Consumer stalls for five cycles; stray acks and sideband must be ignored.
    for (int i = 0; i < 5; i++) begin
      drive(0, i[0], 32'hEEEE_EEEE, 0, 1, 32'h0000_0300, i[1]);
      expect_out($sformatf("stall%0d", i), 0, 32'h10, 1, 32'hD000_0010, 32'h10, 0);
      tick();
    end
    drive(0, 0, 32'h0, 1, 0, 32'h0, 0);
    expect_out("stall_release", 0, 32'h10, 1, 32'hD000_0010, 32'h10, 0);
    tick();
    drive(0, 1, 32'hE000_0014, 0, 0, 32'h0, 0);
    expect_out("after_stall", 1, 32'h14, 0, 32'hD000_0010, 32'h10, 0);
    tick();

    // Exception wins over branch and halts until reset.
    drive(0, 0, 32'h0, 1, 1, 32'h0000_0040, 1);
    expect_out("exc_handshake", 0, 32'h14, 1, 32'hE000_0014, 32'h14, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 32'h5555_5555, 1, 1, 32'h0000_0040, i[0]);
      expect_out($sformatf("halt%0d", i), 0, 32'h14, 0, 32'hE000_0014, 32'h14, 1);
      tick();
    end
    drive(1, 1, 32'h6666_6666, 1, 0, 32'h0, 0);
    expect_out("halt_rst", 0, 32'h0, 0, 32'hE000_0014, 32'h14, 1);
    tick();
    drive(0, 0, 32'h0, 0, 0, 32'h0, 0);
    expect_out("halt_exit", 1, 32'h0, 0, 32'h0, 32'h0, 0);

    // Reset while a request is outstanding with ack present drops the fetch.
    drive(0, 1, 32'hF000_0000, 0, 0, 32'h0, 0);
    tick();
    drive(0, 0, 32'h0, 1, 0, 32'h0, 0);
    expect_out("pre_rst_valid", 0, 32'h0, 1, 32'hF000_0000, 32'h0, 0);
    tick();
    drive(1, 1, 32'h0BAD_0BAD, 1, 0, 32'h0, 0);
    expect_out("rst_with_ack", 0, 32'h4, 0, 32'hF000_0000, 32'h0, 0);
    tick();
    drive(0, 0, 32'h0, 0, 0, 32'h0, 0);
    expect_out("post_rst", 1, 32'h0, 0, 32'h0, 32'h0, 0);
    tick();
    expect_out("post_rst_hold", 1, 32'h0, 0, 32'h0, 32'h0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
